// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central hazard controller for the five-stage F/D/E/M/W pipeline. It drives
// the stall and flush controls of every inter-stage register (including the
// F->D register), selects ALU operand forwarding in E, sequences multi-cycle
// MDU operations held in E, and watches data-memory wait states in M.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   rs1D, rs2D     source registers of the instruction in D
//   rs1E, rs2E     source registers of the instruction in E
//   rdE            destination register of the instruction in E
//   rdM, rdW       destination registers in M and W
//   reg_writeM/W   M / W instruction writes the register file
//   loadE          instruction in E is a load
//   pc_srcE        taken branch or jump resolved in E
//   mdu_startE     instruction in E is a multi-cycle MDU op
//   dmem_reqM      M issues a data-memory access
//   dmem_readyM    data memory completes the access this cycle
//   perf_clr       synchronous clear of stall_cycles
//   stallF..stallM hold PC / stage register
//   flushD..flushW zero stage register (insert a bubble)
//   forwardAE/BE   operand select: 00 regfile, 01 from W, 10 from M
//   mdu_doneE      MDU result valid in E this cycle
//   mdu_busy       MDU sequencer is waiting for the result
//   mem_timeout    sticky memory-timeout error
//   stall_cycles   saturating count of cycles with stallF asserted
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MDU_LATENCY = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        rs1D,
    input  logic [4:0]        rs2D,
    input  logic [4:0]        rs1E,
    input  logic [4:0]        rs2E,
    input  logic [4:0]        rdE,
    input  logic [4:0]        rdM,
    input  logic [4:0]        rdW,
    input  logic              reg_writeM,
    input  logic              reg_writeW,
    input  logic              loadE,
    input  logic              pc_srcE,
    input  logic              mdu_startE,
    input  logic              dmem_reqM,
    input  logic              dmem_readyM,
    input  logic              perf_clr,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              mdu_doneE,
    output logic              mdu_busy,
    output logic              mem_timeout,
    output logic [PERF_W-1:0] stall_cycles
);

    // The MDU countdown only ever holds MDU_LATENCY-2, and the wait counter
    // saturates at MEM_TIMEOUT, so both are sized to those maxima.
    localparam int CNT_W  = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY) : 1;
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0]  MDU_LOAD = CNT_W'(MDU_LATENCY - 2);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MDU_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_mduCnt;
    logic               r_mduBusy;
    logic [WAIT_W-1:0]  r_waitCnt;
    logic               r_memTimeout;
    logic [PERF_W-1:0]  r_stallCycles;

    logic w_memStall;
    logic w_lwStall;
    logic w_mduStall;
    logic w_mduDone;
    logic w_mduWait;

    // Forwarding select for one E-stage source operand. A newer result in M
    // shadows an older one in W; x0 is never forwarded.
    function automatic logic [1:0] fwdSel(
        input logic [4:0] rsE,
        input logic       wrM,
        input logic [4:0] dstM,
        input logic       wrW,
        input logic [4:0] dstW
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (wrM && (dstM != 5'd0) && (dstM == rsE)) begin
            sel = 2'b10;
        end else if (wrW && (dstW != 5'd0) && (dstW == rsE)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign w_mduWait  = (r_state == ST_MDU_WAIT);
    assign w_memStall = dmem_reqM & ~dmem_readyM;
    assign w_lwStall  = loadE & (rdE != 5'd0) & ((rdE == rs1D) | (rdE == rs2D));

    // The start cycle itself stalls, then each wait cycle with a non-zero
    // countdown stalls; the final cycle (count 0) lets the op leave E.
    assign w_mduStall = (~w_mduWait & mdu_startE) | (w_mduWait & (r_mduCnt != '0));

    // A memory wait in M freezes E as well, so the result cannot be taken
    // while memStall holds; it is presented once memory releases.
    assign w_mduDone  = w_mduWait & (r_mduCnt == '0) & ~w_memStall;

    // Stall/flush priority: the memory wait freezes everything up to M and
    // bubbles W; the MDU freezes up to E and bubbles M; a load-use hazard
    // freezes F/D and bubbles E; a taken branch squashes D and E. Since only
    // the top row applies, a branch in E during a memory wait is squashed
    // only after the wait ends. Reset forces bubbles into every stage.
    always_comb begin
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        flushM    = 1'b0;
        flushW    = 1'b0;
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        mdu_doneE = 1'b0;
        if (!reset) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
            flushW = 1'b1;
        end else begin
            forwardAE = fwdSel(rs1E, reg_writeM, rdM, reg_writeW, rdW);
            forwardBE = fwdSel(rs2E, reg_writeM, rdM, reg_writeW, rdW);
            mdu_doneE = w_mduDone;
            if (w_memStall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else if (w_mduStall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                flushM = 1'b1;
            end else if (w_lwStall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end else if (pc_srcE) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    assign mdu_busy     = r_mduBusy;
    assign mem_timeout  = r_memTimeout;
    assign stall_cycles = r_stallCycles;

    // MDU sequencer. An op is not launched while M is waiting on memory,
    // because E is frozen and the op has not really started. The countdown
    // keeps running through memory waits so latency overlaps the wait; at
    // zero the sequencer only returns to RUN once memory lets E advance.
    // Reset drops any op in flight without producing a result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_RUN;
            r_mduCnt  <= '0;
            r_mduBusy <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (mdu_startE && !w_memStall) begin
                        r_state   <= ST_MDU_WAIT;
                        r_mduCnt  <= MDU_LOAD;
                        r_mduBusy <= 1'b1;
                    end
                end
                ST_MDU_WAIT: begin
                    if (r_mduCnt != '0) begin
                        r_mduCnt <= r_mduCnt - CNT_W'(1);
                    end
                    if (w_mduDone) begin
                        r_state   <= ST_RUN;
                        r_mduBusy <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_RUN;
                    r_mduBusy <= 1'b0;
                end
            endcase
        end
    end

    // Memory watchdog: counts consecutive wait cycles. The error latches on
    // a wait cycle seen after MEM_TIMEOUT wait cycles already elapsed, and
    // only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_waitCnt    <= '0;
            r_memTimeout <= 1'b0;
        end else if (w_memStall) begin
            if (r_waitCnt != WAIT_MAX) begin
                r_waitCnt <= r_waitCnt + WAIT_W'(1);
            end else begin
                r_memTimeout <= 1'b1;
            end
        end else begin
            r_waitCnt <= '0;
        end
    end

    // Performance counter of fetch-stall cycles, saturating at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stallCycles <= '0;
        end else if (perf_clr) begin
            r_stallCycles <= '0;
        end else if (stallF && (r_stallCycles != '1)) begin
            r_stallCycles <= r_stallCycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Scoreboard bench for pipeline_hazard_ctrl. Each cycle the stimulus side
// drives inputs, asks the reference model for the expected outputs and queues
// them; an independent monitor pops one entry per cycle on the falling edge
// and compares it with what the DUT shows. The model tracks an MDU op by its
// age in E and the memory watchdog by the length of the current wait run.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int LAT      = 4;
    localparam int MT       = 3;
    localparam int PW       = 8;
    localparam int PERF_MAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [4:0]    rs1D = '0, rs2D = '0, rs1E = '0, rs2E = '0;
    logic [4:0]    rdE = '0, rdM = '0, rdW = '0;
    logic          reg_writeM = 1'b0, reg_writeW = 1'b0, loadE = 1'b0;
    logic          pc_srcE = 1'b0, mdu_startE = 1'b0;
    logic          dmem_reqM = 1'b0, dmem_readyM = 1'b0, perf_clr = 1'b0;
    logic          stallF, stallD, stallE, stallM;
    logic          flushD, flushE, flushM, flushW;
    logic [1:0]    forwardAE, forwardBE;
    logic          mdu_doneE, mdu_busy, mem_timeout;
    logic [PW-1:0] stall_cycles;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .MDU_LATENCY (LAT),
        .MEM_TIMEOUT (MT),
        .PERF_W      (PW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rs1D         (rs1D),
        .rs2D         (rs2D),
        .rs1E         (rs1E),
        .rs2E         (rs2E),
        .rdE          (rdE),
        .rdM          (rdM),
        .rdW          (rdW),
        .reg_writeM   (reg_writeM),
        .reg_writeW   (reg_writeW),
        .loadE        (loadE),
        .pc_srcE      (pc_srcE),
        .mdu_startE   (mdu_startE),
        .dmem_reqM    (dmem_reqM),
        .dmem_readyM  (dmem_readyM),
        .perf_clr     (perf_clr),
        .stallF       (stallF),
        .stallD       (stallD),
        .stallE       (stallE),
        .stallM       (stallM),
        .flushD       (flushD),
        .flushE       (flushE),
        .flushM       (flushM),
        .flushW       (flushW),
        .forwardAE    (forwardAE),
        .forwardBE    (forwardBE),
        .mdu_doneE    (mdu_doneE),
        .mdu_busy     (mdu_busy),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles)
    );

    typedef struct packed {
        logic       rstN;
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic       regWriteM, regWriteW, loadE, pcSrcE, mduStart;
        logic       memReq, memReady, perfClr;
    } stim_t;

    typedef struct packed {
        logic          stallF, stallD, stallE, stallM;
        logic          flushD, flushE, flushM, flushW;
        logic [1:0]    fwdA, fwdB;
        logic          mduDone, mduBusy, memTimeout;
        logic [PW-1:0] stallCycles;
    } exp_t;

    exp_t  expQ[$];
    int    compared   = 0;
    int    mismatched = 0;

    // Reference model state
    bit    mActive   = 1'b0;
    int    mAge      = 0;
    int    memRun    = 0;
    bit    mTimeout  = 1'b0;
    int    mPerf     = 0;
    stim_t prevStim;
    exp_t  prevExp;
    bit    prevValid = 1'b0;

    function automatic logic [1:0] refForward(input logic [4:0] rs, input stim_t s);
        if (s.regWriteM && s.rdM != 5'd0 && s.rdM == rs) return 2'b10;
        if (s.regWriteW && s.rdW != 5'd0 && s.rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic stim_t idleStim();
        stim_t s;
        s      = '0;
        s.rstN = 1'b1;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s.rstN      = ($urandom_range(0, 149) != 0);
        s.rs1D      = 5'($urandom_range(0, 3));
        s.rs2D      = 5'($urandom_range(0, 3));
        s.rs1E      = 5'($urandom_range(0, 3));
        s.rs2E      = 5'($urandom_range(0, 3));
        s.rdE       = 5'($urandom_range(0, 3));
        s.rdM       = 5'($urandom_range(0, 3));
        s.rdW       = 5'($urandom_range(0, 3));
        s.regWriteM = ($urandom_range(0, 1) == 1);
        s.regWriteW = ($urandom_range(0, 1) == 1);
        s.loadE     = ($urandom_range(0, 9) < 3);
        s.pcSrcE    = ($urandom_range(0, 9) < 2);
        s.mduStart  = ($urandom_range(0, 9) < 2);
        s.memReq    = ($urandom_range(0, 9) < 4);
        s.memReady  = ($urandom_range(0, 1) == 1);
        s.perfClr   = ($urandom_range(0, 39) == 0);
        return s;
    endfunction

    // Advance the model across one rising edge given the inputs and outputs
    // of the cycle that just ended.
    task automatic advanceModel(input stim_t s, input exp_t e);
        bit memStall;
        memStall = s.memReq && !s.memReady;
        if (mActive) begin
            if (e.mduDone) mActive = 1'b0;
            else if (mAge < 1000) mAge++;
        end else if (s.mduStart && !memStall) begin
            mActive = 1'b1;
            mAge    = 1;
        end
        if (memStall && memRun >= MT) mTimeout = 1'b1;
        memRun = memStall ? ((memRun < 1000) ? memRun + 1 : memRun) : 0;
        if (s.perfClr) mPerf = 0;
        else if (e.stallF && mPerf < PERF_MAX) mPerf++;
    endtask

    task automatic applyStimulus(input stim_t s);
        exp_t e;
        bit   memStall, lw, mduStall;
        @(posedge clk);
        if (prevValid && prevStim.rstN) advanceModel(prevStim, prevExp);
        #1;
        reset       = s.rstN;
        rs1D        = s.rs1D;
        rs2D        = s.rs2D;
        rs1E        = s.rs1E;
        rs2E        = s.rs2E;
        rdE         = s.rdE;
        rdM         = s.rdM;
        rdW         = s.rdW;
        reg_writeM  = s.regWriteM;
        reg_writeW  = s.regWriteW;
        loadE       = s.loadE;
        pc_srcE     = s.pcSrcE;
        mdu_startE  = s.mduStart;
        dmem_reqM   = s.memReq;
        dmem_readyM = s.memReady;
        perf_clr    = s.perfClr;
        e = '0;
        if (!s.rstN) begin
            mActive  = 1'b0;
            mAge     = 0;
            memRun   = 0;
            mTimeout = 1'b0;
            mPerf    = 0;
            e.flushD = 1'b1;
            e.flushE = 1'b1;
            e.flushM = 1'b1;
            e.flushW = 1'b1;
        end else begin
            memStall = s.memReq && !s.memReady;
            lw       = s.loadE && s.rdE != 5'd0 && (s.rdE == s.rs1D || s.rdE == s.rs2D);
            // An op stalls E on its start cycle and on every later cycle
            // until it has spent LAT-1 cycles in E.
            mduStall = mActive ? (mAge < LAT - 1) : s.mduStart;
            e.fwdA   = refForward(s.rs1E, s);
            e.fwdB   = refForward(s.rs2E, s);
            e.mduDone     = mActive && (mAge >= LAT - 1) && !memStall;
            e.mduBusy     = mActive;
            e.memTimeout  = mTimeout;
            e.stallCycles = PW'(mPerf);
            if (memStall) begin
                {e.stallF, e.stallD, e.stallE, e.stallM, e.flushW} = 5'b11111;
            end else if (mduStall) begin
                {e.stallF, e.stallD, e.stallE, e.flushM} = 4'b1111;
            end else if (lw) begin
                {e.stallF, e.stallD, e.flushE} = 3'b111;
            end else if (s.pcSrcE) begin
                {e.flushD, e.flushE} = 2'b11;
            end
        end
        expQ.push_back(e);
        prevStim  = s;
        prevExp   = e;
        prevValid = 1'b1;
    endtask

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, want);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("stallF",       32'(stallF),       32'(e.stallF));
        checkField("stallD",       32'(stallD),       32'(e.stallD));
        checkField("stallE",       32'(stallE),       32'(e.stallE));
        checkField("stallM",       32'(stallM),       32'(e.stallM));
        checkField("flushD",       32'(flushD),       32'(e.flushD));
        checkField("flushE",       32'(flushE),       32'(e.flushE));
        checkField("flushM",       32'(flushM),       32'(e.flushM));
        checkField("flushW",       32'(flushW),       32'(e.flushW));
        checkField("forwardAE",    32'(forwardAE),    32'(e.fwdA));
        checkField("forwardBE",    32'(forwardBE),    32'(e.fwdB));
        checkField("mdu_doneE",    32'(mdu_doneE),    32'(e.mduDone));
        checkField("mdu_busy",     32'(mdu_busy),     32'(e.mduBusy));
        checkField("mem_timeout",  32'(mem_timeout),  32'(e.memTimeout));
        checkField("stall_cycles", 32'(stall_cycles), 32'(e.stallCycles));
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (expQ.size() != 0) checkOutput(expQ.pop_front());
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", compared);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;

        s = idleStim();
        s.rstN = 1'b0;
        applyStimulus(s);
        applyStimulus(s);
        s = idleStim();
        applyStimulus(s);

        // Load-use hazard, then the same with x0 as destination.
        s = idleStim();
        s.loadE = 1'b1; s.rdE = 5'd5; s.rs1D = 5'd5;
        applyStimulus(s);
        s.rdE = 5'd0; s.rs1D = 5'd0;
        applyStimulus(s);

        // Forwarding priority M over W, then W alone, then x0.
        s = idleStim();
        s.regWriteM = 1'b1; s.regWriteW = 1'b1;
        s.rdM = 5'd7; s.rdW = 5'd7; s.rs1E = 5'd7; s.rs2E = 5'd7;
        applyStimulus(s);
        s.regWriteM = 1'b0;
        applyStimulus(s);
        s.regWriteM = 1'b1; s.rdM = 5'd0; s.rdW = 5'd0;
        applyStimulus(s);

        // Unobstructed MDU op with start held for its full occupancy.
        s = idleStim();
        s.perfClr = 1'b1;
        applyStimulus(s);
        s = idleStim();
        s.mduStart = 1'b1;
        repeat (LAT) applyStimulus(s);
        s = idleStim();
        repeat (2) applyStimulus(s);

        // MDU op overlapped with a five-cycle memory wait.
        s = idleStim();
        s.mduStart = 1'b1;
        applyStimulus(s);
        s.memReq = 1'b1;
        repeat (5) applyStimulus(s);
        s.memReady = 1'b1;
        applyStimulus(s);
        s = idleStim();
        repeat (2) applyStimulus(s);

        // Branch alone, then branch held behind a memory wait.
        s = idleStim();
        s.pcSrcE = 1'b1;
        applyStimulus(s);
        s.memReq = 1'b1;
        repeat (3) applyStimulus(s);
        s.memReady = 1'b1;
        applyStimulus(s);

        // Long memory wait: timeout latches and the counter saturates.
        s = idleStim();
        s.perfClr = 1'b1;
        applyStimulus(s);
        s = idleStim();
        s.memReq = 1'b1;
        repeat (PERF_MAX + 20) applyStimulus(s);
        s.memReady = 1'b1;
        applyStimulus(s);
        s = idleStim();
        repeat (2) applyStimulus(s);

        // Reset in the middle of an MDU op.
        s = idleStim();
        s.mduStart = 1'b1;
        repeat (2) applyStimulus(s);
        s.rstN = 1'b0;
        repeat (2) applyStimulus(s);
        s = idleStim();
        repeat (3) applyStimulus(s);

        for (int i = 0; i < 2500; i++) begin
            applyStimulus(randStim());
        end

        repeat (2) @(negedge clk);
        #1;
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
